// File: rtl/pcq_trace_pkg.sv
// Shared constants for the pcq trace capture block: state encodings,
// coretrace bit positions and default geometry.
package pcq_trace_pkg;

   localparam int unsigned DEPTH_DEF = 32;
   localparam int unsigned DW_DEF    = 32;
   localparam int unsigned PCW_DEF   = 8;

   localparam logic [1:0] TC_IDLE   = 2'b00;
   localparam logic [1:0] TC_ARMED  = 2'b01;
   localparam logic [1:0] TC_POST   = 2'b10;
   localparam logic [1:0] TC_FROZEN = 2'b11;

   localparam int unsigned CT_VALID    = 0;
   localparam int unsigned CT_EXT_TRIG = 1;

   typedef enum logic [1:0] {
      StIdle   = TC_IDLE,
      StArmed  = TC_ARMED,
      StPost   = TC_POST,
      StFrozen = TC_FROZEN
   } tc_state_e;

endpackage

// File: rtl/pcq_trace_capture_if.sv
// Debug bus, trace control and readback signals between the debug mux,
// SCOM register block and the trace capture unit.
interface pcq_trace_capture_if #(
   parameter int unsigned DW  = 32,
   parameter int unsigned AW  = 5,
   parameter int unsigned PCW = 8
);
   logic [DW-1:0]  dbg_bus_in;
   logic [3:0]     coretrace_in;
   logic           tc_arm;
   logic           tc_stop;
   logic [DW-1:0]  tc_trig_pattern;
   logic [DW-1:0]  tc_trig_mask;
   logic           tc_trig_ext_en;
   logic [PCW-1:0] tc_post_count;
   logic           rd_req;
   logic [AW-1:0]  rd_addr;
   logic           rd_ack;
   logic [DW-1:0]  rd_data;
   logic [1:0]     tc_state;
   logic           tc_wrapped;
   logic [AW-1:0]  tc_wr_ptr;
   logic           tc_triggered;

   modport master (
      output dbg_bus_in, coretrace_in, tc_arm, tc_stop, tc_trig_pattern, tc_trig_mask,
             tc_trig_ext_en, tc_post_count, rd_req, rd_addr,
      input  rd_ack, rd_data, tc_state, tc_wrapped, tc_wr_ptr, tc_triggered
   );

   modport slave (
      input  dbg_bus_in, coretrace_in, tc_arm, tc_stop, tc_trig_pattern, tc_trig_mask,
             tc_trig_ext_en, tc_post_count, rd_req, rd_addr,
      output rd_ack, rd_data, tc_state, tc_wrapped, tc_wr_ptr, tc_triggered
   );
endinterface

// File: rtl/pcq_trace_array.sv
// DEPTH x DW trace storage: one write port, one synchronous read port.
// A read of the index being written in the same cycle returns the old entry.
module pcq_trace_array #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // Storage is deliberately unreset; contents are undefined until written.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/pcq_trace_capture.sv
// Circular trace capture of the registered debug bus: armed by software,
// frozen a programmable number of samples after a trigger, read back by offset.
module pcq_trace_capture
   import pcq_trace_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = $clog2(DEPTH),
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned PCW   = PCW_DEF
) (
   input  logic                nclk,
   input  logic                rst_b,
   pcq_trace_capture_if.slave  tc_io
);

   tc_state_e      state_q, state_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic           wrapped_q, wrapped_d;
   logic           triggered_q, triggered_d;
   logic [PCW-1:0] cnt_q, cnt_d;
   logic           rd_ack_q;
   logic           rd_oob_q;

   logic           capturing;
   logic           sample;
   logic           mask_hit;
   logic           ext_hit;
   logic           trig_hit;
   logic           wr_en;
   logic [AW-1:0]  rd_phys;
   logic           rd_oob;
   logic [DW-1:0]  arr_rdata;
   logic           unused_ct;

   assign unused_ct = ^tc_io.coretrace_in[3:2];

   assign capturing = (state_q == StArmed) || (state_q == StPost);
   assign sample    = capturing && tc_io.coretrace_in[CT_VALID];

   // An all-zero mask would match every word, so it disables the pattern compare.
   assign mask_hit = (tc_io.tc_trig_mask != '0) &&
                     (((tc_io.dbg_bus_in ^ tc_io.tc_trig_pattern) & tc_io.tc_trig_mask) == '0);
   assign ext_hit  = tc_io.tc_trig_ext_en && tc_io.coretrace_in[CT_EXT_TRIG];
   assign trig_hit = tc_io.coretrace_in[CT_VALID] && (mask_hit || ext_hit);

   always_ff @(posedge nclk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         wrapped_q   <= 1'b0;
         triggered_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         wrapped_q   <= wrapped_d;
         triggered_q <= triggered_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wrapped_d   = wrapped_q;
      triggered_d = triggered_q;
      cnt_d       = cnt_q;
      wr_en       = 1'b0;

      // Arm overrides everything, including a simultaneous stop or sample.
      if (tc_io.tc_arm) begin
         state_d     = StArmed;
         wr_ptr_d    = '0;
         wrapped_d   = 1'b0;
         triggered_d = 1'b0;
         cnt_d       = '0;
      end else begin
         unique case (state_q)
            StArmed: begin
               if (tc_io.tc_stop) begin
                  state_d = StFrozen;
               end else if (sample) begin
                  wr_en = 1'b1;
                  if (trig_hit) begin
                     triggered_d = 1'b1;
                     cnt_d       = tc_io.tc_post_count;
                     state_d     = (tc_io.tc_post_count == '0) ? StFrozen : StPost;
                  end
               end
            end
            StPost: begin
               if (tc_io.tc_stop) begin
                  state_d = StFrozen;
               end else if (sample) begin
                  wr_en = 1'b1;
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == PCW'(1)) begin
                     state_d = StFrozen;
                  end
               end
            end
            StIdle, StFrozen: begin
            end
            default: state_d = StIdle;
         endcase

         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == AW'(DEPTH - 1)) begin
               wrapped_d = 1'b1;
            end
         end
      end
   end

   // Offset 0 is the oldest entry: index 0 before the first wrap, wr_ptr after.
   assign rd_phys = (wrapped_q ? wr_ptr_q : '0) + tc_io.rd_addr;
   assign rd_oob  = !wrapped_q && (tc_io.rd_addr >= wr_ptr_q);

   always_ff @(posedge nclk or negedge rst_b) begin
      if (!rst_b) begin
         rd_ack_q <= 1'b0;
         rd_oob_q <= 1'b0;
      end else begin
         rd_ack_q <= tc_io.rd_req;
         if (tc_io.rd_req) begin
            rd_oob_q <= rd_oob;
         end
      end
   end

   pcq_trace_array #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_array (
      .clk_i   (nclk),
      .rst_ni  (rst_b),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (tc_io.dbg_bus_in),
      .re_i    (tc_io.rd_req),
      .raddr_i (rd_phys),
      .rdata_o (arr_rdata)
   );

   assign tc_io.rd_ack       = rd_ack_q;
   assign tc_io.rd_data      = rd_oob_q ? '0 : arr_rdata;
   assign tc_io.tc_state     = state_q;
   assign tc_io.tc_wrapped   = wrapped_q;
   assign tc_io.tc_wr_ptr    = wr_ptr_q;
   assign tc_io.tc_triggered = triggered_q;

endmodule

// File: tb/tb_pcq_trace_capture.sv
// Self-checking bench for pcq_trace_capture: status checks per scenario and a
// readback scoreboard whose expectations are queued when each request is issued.
module tb_pcq_trace_capture;
   import pcq_trace_pkg::*;

   localparam int unsigned DEPTH = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;
   localparam int unsigned PCW   = 8;
   localparam logic [31:0] PAT   = 32'hDEAD_BEEF;

   logic nclk  = 1'b0;
   logic rst_b = 1'b0;
   always #5 nclk = ~nclk;

   pcq_trace_capture_if #(.DW(DW), .AW(AW), .PCW(PCW)) ifc ();

   pcq_trace_capture #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW),
      .PCW   (PCW)
   ) dut (
      .nclk  (nclk),
      .rst_b (rst_b),
      .tc_io (ifc.slave)
   );

   int          checks  = 0;
   int          errors  = 0;
   int          ack_cnt = 0;
   logic [31:0] exp_q [$];

   // Readback scoreboard: every ack pops the oldest outstanding expectation.
   always @(negedge nclk) begin : rd_monitor
      logic [31:0] e;
      if (ifc.rd_ack === 1'b1) begin
         ack_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_ack_unexpected got data %h with no request pending", ifc.rd_data);
         end else begin
            e = exp_q.pop_front();
            if (ifc.rd_data !== e) begin
               errors++;
               $display("FAIL rd_data got %h exp %h", ifc.rd_data, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   function automatic logic [31:0] sd(input int i);
      return 32'h1000_0000 + 32'(i);
   endfunction

   task automatic step();
      @(posedge nclk);
      #1;
   endtask

   task automatic drive_sample(input logic [31:0] d, input logic v, input logic ext);
      ifc.dbg_bus_in   = d;
      ifc.coretrace_in = {2'b00, ext, v};
      step();
      ifc.coretrace_in = 4'b0000;
   endtask

   task automatic arm();
      ifc.tc_arm = 1'b1;
      step();
      ifc.tc_arm = 1'b0;
   endtask

   task automatic config_trig(input logic [31:0] mask, input logic ext_en, input int post);
      ifc.tc_trig_mask    = mask;
      ifc.tc_trig_pattern = PAT;
      ifc.tc_trig_ext_en  = ext_en;
      ifc.tc_post_count   = PCW'(post);
   endtask

   task automatic rd_one(input logic [AW-1:0] a, input logic [31:0] e);
      exp_q.push_back(e);
      ifc.rd_req  = 1'b1;
      ifc.rd_addr = a;
      step();
      ifc.rd_req = 1'b0;
      step();
   endtask

   task automatic test_reset();
      ifc.dbg_bus_in      = '0;
      ifc.coretrace_in    = '0;
      ifc.tc_arm          = 1'b0;
      ifc.tc_stop         = 1'b0;
      ifc.tc_trig_pattern = '0;
      ifc.tc_trig_mask    = '0;
      ifc.tc_trig_ext_en  = 1'b0;
      ifc.tc_post_count   = '0;
      ifc.rd_req          = 1'b0;
      ifc.rd_addr         = '0;
      repeat (3) step();
      rst_b = 1'b1;
      step();
      checks++;
      if ({ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered} !==
          {TC_IDLE, 5'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_status got %b exp %b",
                  {ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered},
                  {TC_IDLE, 5'd0, 1'b0, 1'b0});
      end
      checks++;
      if ({ifc.rd_ack, ifc.rd_data} !== 33'd0) begin
         errors++;
         $display("FAIL reset_rd got ack %b data %h exp 0 0", ifc.rd_ack, ifc.rd_data);
      end
   endtask

   task automatic test_trigger_basic();
      config_trig(32'hFFFF_FFFF, 1'b0, 3);
      arm();
      checks++;
      if (ifc.tc_state !== TC_ARMED) begin
         errors++;
         $display("FAIL basic_armed got %b exp %b", ifc.tc_state, TC_ARMED);
      end
      for (int i = 0; i < 14; i++) begin
         drive_sample((i == 10) ? PAT : sd(i), 1'b1, 1'b0);
         if (i == 10) begin
            checks++;
            if ({ifc.tc_state, ifc.tc_triggered} !== {TC_POST, 1'b1}) begin
               errors++;
               $display("FAIL basic_post got %b exp %b", {ifc.tc_state, ifc.tc_triggered},
                        {TC_POST, 1'b1});
            end
         end
      end
      drive_sample(sd(99), 1'b1, 1'b0);
      checks++;
      if ({ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered} !==
          {TC_FROZEN, 5'd14, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL basic_frozen got %b exp %b",
                  {ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered},
                  {TC_FROZEN, 5'd14, 1'b0, 1'b1});
      end
      rd_one(5'd10, PAT);
      rd_one(5'd0, sd(0));
      rd_one(5'd13, sd(13));
      rd_one(5'd14, 32'd0);
      rd_one(5'd31, 32'd0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_drain got %0d pending exp 0", exp_q.size());
      end
   endtask

   task automatic test_wrap();
      config_trig(32'hFFFF_FFFF, 1'b0, 5);
      arm();
      for (int i = 0; i < 46; i++) begin
         drive_sample((i == 40) ? PAT : sd(i), 1'b1, 1'b0);
      end
      checks++;
      if ({ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered} !==
          {TC_FROZEN, 5'd14, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL wrap_status got %b exp %b",
                  {ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered},
                  {TC_FROZEN, 5'd14, 1'b1, 1'b1});
      end
      rd_one(5'd0, sd(14));
      rd_one(5'd31, sd(45));
      rd_one(5'd26, PAT);
      rd_one(5'd17, sd(31));
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_drain got %0d pending exp 0", exp_q.size());
      end
   endtask

   task automatic test_ext_trigger();
      config_trig(32'h0, 1'b1, 0);
      arm();
      for (int i = 0; i < 6; i++) begin
         drive_sample(sd(i), 1'b1, (i == 5));
      end
      checks++;
      if ({ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered} !==
          {TC_FROZEN, 5'd6, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL ext_status got %b exp %b",
                  {ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered},
                  {TC_FROZEN, 5'd6, 1'b0, 1'b1});
      end
      drive_sample(sd(50), 1'b1, 1'b1);
      checks++;
      if (ifc.tc_wr_ptr !== 5'd6) begin
         errors++;
         $display("FAIL ext_no_write got %0d exp 6", ifc.tc_wr_ptr);
      end
      rd_one(5'd5, sd(5));
      rd_one(5'd6, 32'd0);
   endtask

   task automatic test_no_trigger();
      config_trig(32'hFFFF_FFFF, 1'b1, 3);
      arm();
      repeat (3) drive_sample(PAT, 1'b0, 1'b1);
      checks++;
      if ({ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered} !==
          {TC_ARMED, 5'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL novalid_status got %b exp %b",
                  {ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered},
                  {TC_ARMED, 5'd0, 1'b0, 1'b0});
      end
      config_trig(32'h0, 1'b0, 3);
      for (int i = 0; i < 100; i++) begin
         drive_sample((i % 2 == 1) ? PAT : 32'd0, 1'b1, 1'b1);
      end
      checks++;
      if ({ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered} !==
          {TC_ARMED, 5'd4, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL zeromask_status got %b exp %b",
                  {ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered},
                  {TC_ARMED, 5'd4, 1'b1, 1'b0});
      end
   endtask

   task automatic test_stop_arm();
      config_trig(32'hFFFF_FFFF, 1'b0, 8);
      arm();
      for (int i = 0; i < 7; i++) begin
         drive_sample((i == 2) ? PAT : sd(i), 1'b1, 1'b0);
      end
      checks++;
      if ({ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_triggered} !== {TC_POST, 5'd7, 1'b1}) begin
         errors++;
         $display("FAIL stop_pre got %b exp %b", {ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_triggered},
                  {TC_POST, 5'd7, 1'b1});
      end
      ifc.tc_stop = 1'b1;
      drive_sample(sd(7), 1'b1, 1'b0);
      ifc.tc_stop = 1'b0;
      drive_sample(sd(8), 1'b1, 1'b0);
      checks++;
      if ({ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_triggered} !== {TC_FROZEN, 5'd7, 1'b1}) begin
         errors++;
         $display("FAIL stop_frozen got %b exp %b",
                  {ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_triggered}, {TC_FROZEN, 5'd7, 1'b1});
      end
      rd_one(5'd6, sd(6));
      rd_one(5'd7, 32'd0);
      ifc.tc_arm  = 1'b1;
      ifc.tc_stop = 1'b1;
      drive_sample(PAT, 1'b1, 1'b0);
      ifc.tc_arm  = 1'b0;
      ifc.tc_stop = 1'b0;
      checks++;
      if ({ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered} !==
          {TC_ARMED, 5'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL arm_stop got %b exp %b",
                  {ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_wrapped, ifc.tc_triggered},
                  {TC_ARMED, 5'd0, 1'b0, 1'b0});
      end
      drive_sample(sd(0), 1'b1, 1'b0);
      checks++;
      if ({ifc.tc_state, ifc.tc_wr_ptr} !== {TC_ARMED, 5'd1}) begin
         errors++;
         $display("FAIL rearm_capture got %b exp %b", {ifc.tc_state, ifc.tc_wr_ptr},
                  {TC_ARMED, 5'd1});
      end
   endtask

   task automatic test_async_reset();
      config_trig(32'hFFFF_FFFF, 1'b0, 10);
      arm();
      drive_sample(PAT, 1'b1, 1'b0);
      ifc.rd_req  = 1'b1;
      ifc.rd_addr = 5'd0;
      step();
      ifc.rd_req = 1'b0;
      checks++;
      if ({ifc.tc_state, ifc.rd_ack} !== {TC_POST, 1'b1}) begin
         errors++;
         $display("FAIL prereset got %b exp %b", {ifc.tc_state, ifc.rd_ack}, {TC_POST, 1'b1});
      end
      #1 rst_b = 1'b0;
      #1;
      checks++;
      if ({ifc.tc_state, ifc.tc_triggered, ifc.rd_ack, ifc.tc_wr_ptr, ifc.rd_data} !==
          {TC_IDLE, 1'b0, 1'b0, 5'd0, 32'd0}) begin
         errors++;
         $display("FAIL async_reset got %h exp %h",
                  {ifc.tc_state, ifc.tc_triggered, ifc.rd_ack, ifc.tc_wr_ptr, ifc.rd_data},
                  {TC_IDLE, 1'b0, 1'b0, 5'd0, 32'd0});
      end
      step();
      rst_b = 1'b1;
      drive_sample(PAT, 1'b1, 1'b0);
      checks++;
      if ({ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_triggered} !== {TC_IDLE, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL idle_no_capture got %b exp %b",
                  {ifc.tc_state, ifc.tc_wr_ptr, ifc.tc_triggered}, {TC_IDLE, 5'd0, 1'b0});
      end
   endtask

   task automatic test_back_to_back();
      int ack_before;
      config_trig(32'h0, 1'b0, 0);
      arm();
      for (int i = 0; i < 8; i++) begin
         drive_sample(sd(100 + i), 1'b1, 1'b0);
      end
      ifc.tc_stop = 1'b1;
      step();
      ifc.tc_stop = 1'b0;
      checks++;
      if ({ifc.tc_state, ifc.tc_wr_ptr} !== {TC_FROZEN, 5'd8}) begin
         errors++;
         $display("FAIL b2b_status got %b exp %b", {ifc.tc_state, ifc.tc_wr_ptr},
                  {TC_FROZEN, 5'd8});
      end
      ack_before = ack_cnt;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(sd(100 + 2 * i));
         ifc.rd_req  = 1'b1;
         ifc.rd_addr = AW'(2 * i);
         step();
         checks++;
         if (ifc.rd_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ack%0d got %b exp 1", i, ifc.rd_ack);
         end
      end
      ifc.rd_req = 1'b0;
      step();
      checks++;
      if ((ack_cnt - ack_before) != 4 || ifc.rd_ack !== 1'b0) begin
         errors++;
         $display("FAIL b2b_count got %0d acks (ack now %b) exp 4 (ack 0)",
                  ack_cnt - ack_before, ifc.rd_ack);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain got %0d pending exp 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_trigger_basic();
      test_wrap();
      test_ext_trigger();
      test_no_trigger();
      test_stop_arm();
      test_async_reset();
      test_back_to_back();
      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
